// File: rtl/ins_decoder.sv
// Instruction decoder/dispatcher: routes load/save to mem_*, calc to calc_info, and applies
// config instructions only after all units are idle. Optional legality checks: `INS_DEC_CHECK_EN.
module ins_decoder #(
    parameter int INS_W = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INS_W-1:0] ins,
    input  logic             ins_valid,
    output logic             ins_ready,
    output logic             ld_valid,
    input  logic             ld_ready,
    output logic             sv_valid,
    input  logic             sv_ready,
    output logic [3:0]       mem_op,
    output logic [5:0]       mem_buf_id,
    output logic [11:0]      mem_size,
    output logic [7:0]       mem_aux,
    output logic [31:0]      mem_addr,
    output logic             calc_valid,
    input  logic             calc_ready,
    output logic [27:0]      calc_info,
    input  logic             ld_idle,
    input  logic             calc_idle,
    input  logic             sv_idle,
    output logic             conf_valid,
    output logic [29:0]      conf_info,
    output logic             err,
    output logic [1:0]       err_type,
    output logic [CNT_W-1:0] ins_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_SYNC
    } state_t;

    typedef enum logic [1:0] {
        T_LOAD = 2'b00,
        T_CALC = 2'b01,
        T_SAVE = 2'b10,
        T_CONF = 2'b11
    } ins_type_t;

    state_t     r_state, w_next_state;
    ins_type_t  r_type;
    ins_type_t  w_in_type;

    logic [3:0]       r_mem_op;
    logic [5:0]       r_mem_buf_id;
    logic [11:0]      r_mem_size;
    logic [7:0]       r_mem_aux;
    logic [31:0]      r_mem_addr;
    logic [27:0]      r_calc_info;
    logic [29:0]      r_conf_hold;
    logic [29:0]      r_conf_info;
    logic             r_conf_valid;
    logic [CNT_W-1:0] r_cnt;

    logic w_sel_ready, w_hold_done, w_sync_done, w_accept, w_illegal, w_take;

    assign w_in_type = ins_type_t'(ins[63:62]);

    always_comb begin
        unique case (r_type)
            T_LOAD:  w_sel_ready = ld_ready;
            T_CALC:  w_sel_ready = calc_ready;
            default: w_sel_ready = sv_ready;
        endcase
    end

    assign w_hold_done = (r_state == S_HOLD) && w_sel_ready;
    assign w_sync_done = (r_state == S_SYNC) && ld_idle && calc_idle && sv_idle;
    assign ins_ready   = (r_state == S_IDLE) || w_hold_done;
    assign w_accept    = ins_valid && ins_ready;

`ifdef INS_DEC_CHECK_EN
    logic r_err;
    logic [1:0] r_err_type;

    always_comb begin
        w_illegal = 1'b0;
        unique case (w_in_type)
            T_LOAD:  w_illegal = !(ins[61:58] inside {4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7});
            T_SAVE:  w_illegal = !(ins[61:58] inside {4'd0, 4'd8, 4'd9, 4'd10, 4'd11});
            T_CONF:  w_illegal = (ins[61:58] > 4'd5);
            default: w_illegal = (ins[61:60] != 2'b00);
        endcase
    end

    // Only the first illegal instruction is recorded; later ones are dropped silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err      <= 1'b0;
            r_err_type <= 2'b00;
        end else if (w_accept && w_illegal && !r_err) begin
            r_err      <= 1'b1;
            r_err_type <= ins[63:62];
        end
    end

    assign err      = r_err;
    assign err_type = r_err_type;
`else
    assign w_illegal = 1'b0;
    assign err       = 1'b0;
    assign err_type  = 2'b00;
`endif

    assign w_take = w_accept && !w_illegal;

    // NOTE: every variable in this block gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE, S_HOLD: begin
                if (r_state == S_IDLE || w_hold_done) begin
                    if (w_take)
                        w_next_state = (w_in_type == T_CONF) ? S_SYNC : S_HOLD;
                    else
                        w_next_state = S_IDLE;
                end
            end
            S_SYNC: begin
                if (w_sync_done)
                    w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // NOTE: the holding/payload registers are reset too, since their reset value is visible on outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_type       <= T_LOAD;
            r_mem_op     <= '0;
            r_mem_buf_id <= '0;
            r_mem_size   <= '0;
            r_mem_aux    <= '0;
            r_mem_addr   <= '0;
            r_calc_info  <= '0;
            r_conf_hold  <= '0;
            r_conf_info  <= '0;
            r_conf_valid <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_next_state;
            r_conf_valid <= w_sync_done;
            if (w_hold_done || w_sync_done)
                r_cnt <= r_cnt + 1'b1;
            if (w_sync_done)
                r_conf_info <= r_conf_hold;
            if (w_take) begin
                r_type <= w_in_type;
                // Only the target port's payload changes; the others keep their last value.
                unique case (w_in_type)
                    T_LOAD, T_SAVE: begin
                        r_mem_op     <= ins[61:58];
                        r_mem_buf_id <= ins[57:52];
                        r_mem_size   <= ins[51:40];
                        r_mem_aux    <= ins[39:32];
                        r_mem_addr   <= ins[31:0];
                    end
                    T_CALC:  r_calc_info <= ins[59:32];
                    default: r_conf_hold <= ins[61:32];
                endcase
            end
        end
    end

    assign ld_valid   = (r_state == S_HOLD) && (r_type == T_LOAD);
    assign calc_valid = (r_state == S_HOLD) && (r_type == T_CALC);
    assign sv_valid   = (r_state == S_HOLD) && (r_type == T_SAVE);

    assign mem_op     = r_mem_op;
    assign mem_buf_id = r_mem_buf_id;
    assign mem_size   = r_mem_size;
    assign mem_aux    = r_mem_aux;
    assign mem_addr   = r_mem_addr;
    assign calc_info  = r_calc_info;
    assign conf_valid = r_conf_valid;
    assign conf_info  = r_conf_info;
    assign ins_cnt    = r_cnt;

endmodule
